// File: rtl/ccta_operand_recover.sv
// ----------------------------------------------------------------------------
// ccta_operand_recover
//
// Bit-serial inverse of the CCTA add/subtract unit. From a 5-bit CCTA result
// q, the known operand A and the ctrl select, recovers the missing 4-bit
// operand:
//   ctrl=0 : q = A + B  ->  operand = B = q - A
//   ctrl=1 : q = A - C  ->  operand = C = A - q
// D = minuend - subtrahend (mod 32) is produced one bit per cycle, LSB first,
// by a single full subtractor with a borrow flop.
//
// Optional feature macro: CCTA_OPERAND_RECOVER_RANGE_CHECK_EN
//   defined   : err = D[4], and for ctrl=0 also forced high when q = 31.
//   undefined : err is tied to 0 and no bit-4 result storage is built.
// ----------------------------------------------------------------------------
module ccta_operand_recover (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] q,
    input  logic [3:0] A,
    input  logic       ctrl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] operand,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control state
    state_t     r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [2:0] r_cnt;

    // Serial datapath
    logic [4:0] r_min;
    logic [4:0] r_sub;
    logic       r_borrow;
    logic [3:0] r_res;
    logic [3:0] r_operand;

    // Bit-slice signals
    logic w_accept;
    logic w_calc;
    logic w_last;
    logic w_m;
    logic w_s;
    logic w_d;
    logic w_b_out;

    assign w_accept = in_valid && r_in_ready;
    assign w_calc   = (r_state == S_CALC);
    assign w_last   = (r_cnt == 3'd4);

    // One-bit full subtractor: d = m - s - borrow_in
    assign w_m     = r_min[0];
    assign w_s     = r_sub[0];
    assign w_d     = w_m ^ w_s ^ r_borrow;
    assign w_b_out = (~w_m & w_s) | (~(w_m ^ w_s) & r_borrow);

    // Handshake FSM with registered in_ready/out_valid and the bit counter
    // NOTE: every sequential assignment uses <= so all flops sample the same
    // pre-edge values; a blocking = here would let later lines see new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_cnt      <= 3'd0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_cnt       <= 3'd0;
                end
            endcase
        end
    end

    // Operand shift registers and partial result: loaded on accept, shifted in CALC
    // NOTE: these are deliberately not reset; they are always reloaded on
    // accept before being read, so a reset would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_min <= ctrl ? {1'b0, A} : q;
            r_sub <= ctrl ? q : {1'b0, A};
        end else if (w_calc) begin
            r_min <= r_min >> 1;
            r_sub <= r_sub >> 1;
            if (!w_last) begin
                r_res <= {w_d, r_res[3:1]};
            end
        end
    end

    // Borrow flop and visible result; result only moves on CALC->DONE or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_borrow  <= 1'b0;
            r_operand <= 4'd0;
        end else if (w_accept) begin
            r_borrow <= 1'b0;
        end else if (w_calc) begin
            r_borrow <= w_b_out;
            if (w_last) begin
                r_operand <= r_res;
            end
        end
    end

`ifdef CCTA_OPERAND_RECOVER_RANGE_CHECK_EN
    logic r_q_overflow;
    logic r_err;

    // Capture the out-of-range sum flag at accept (q=31 can never be a 4+4 bit sum)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_overflow <= !ctrl && (q == 5'd31);
        end
    end

    // Bit 4 of D is the error; it goes straight into the err register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_calc && w_last) begin
            r_err <= w_d | r_q_overflow;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign operand   = r_operand;

endmodule

// File: tb/tb_ccta_operand_recover.sv
// ----------------------------------------------------------------------------
// tb_ccta_operand_recover
//
// Directed self-checking bench for ccta_operand_recover. Expected results come
// from an arithmetic model, are queued at accept time and popped when the DUT
// presents a result. Honours CCTA_OPERAND_RECOVER_RANGE_CHECK_EN for err.
// ----------------------------------------------------------------------------
module tb_ccta_operand_recover;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] q;
    logic [3:0] A;
    logic       ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] operand;
    logic       err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] operand;
        logic       err;
    } exp_t;

    exp_t sb[$];

    ccta_operand_recover dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .A         (A),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand   (operand),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word modular subtraction
    function automatic exp_t model(input logic c, input logic [3:0] a, input logic [4:0] qq);
        logic [4:0] d;
        exp_t       e;
        d = c ? ({1'b0, a} - qq) : (qq - {1'b0, a});
        e.operand = d[3:0];
`ifdef CCTA_OPERAND_RECOVER_RANGE_CHECK_EN
        e.err = d[4] | (!c && (qq == 5'd31));
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    // Present one input, confirm it is accepted on the next edge (E0)
    task automatic send(input logic c, input logic [3:0] a, input logic [4:0] qq);
        ctrl     = c;
        A        = a;
        q        = qq;
        in_valid = 1'b1;
        check("send_in_ready", 8'(in_ready), 8'd1);
        step();
        in_valid = 1'b0;
        sb.push_back(model(c, a, qq));
    endtask

    // Wait for the result, optionally hold backpressure and scramble inputs, then handshake
    task automatic collect(input int hold, input bit noise);
        int         n;
        logic [3:0] op_h;
        logic       err_h;
        exp_t       e;
        n = 0;
        while (!out_valid && n < 20) begin
            if (noise) begin
                in_valid = ~in_valid;
                q        = 5'($urandom);
                A        = 4'($urandom);
                ctrl     = 1'($urandom);
            end
            step();
            n++;
            check("busy_in_ready", 8'(in_ready), 8'd0);
        end
        check("latency", 8'(n), 8'd5);
        op_h  = operand;
        err_h = err;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                q        = 5'($urandom);
                A        = 4'($urandom);
            end
            step();
            check("bp_out_valid", 8'(out_valid), 8'd1);
            check("bp_operand", 8'(operand), 8'(op_h));
            check("bp_err", 8'(err), 8'(err_h));
            check("bp_in_ready", 8'(in_ready), 8'd0);
        end
        check("sb_pending", 8'(sb.size()), 8'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check("operand", 8'(operand), 8'(e.operand));
        check("err", 8'(err), 8'(e.err));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hs_out_valid", 8'(out_valid), 8'd0);
        check("hs_in_ready", 8'(in_ready), 8'd1);
    endtask

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q         = 5'd0;
        A         = 4'd0;
        ctrl      = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_operand", 8'(operand), 8'd0);
        check("rst_err", 8'(err), 8'd0);

        // Add, subtract, inconsistent and boundary cases
        send(1'b0, 4'd5, 5'd12);  collect(0, 1'b0);
        send(1'b1, 4'd3, 5'd28);  collect(3, 1'b0);
        send(1'b0, 4'd9, 5'd4);   collect(0, 1'b0);
        send(1'b0, 4'd15, 5'd30); collect(0, 1'b0);
        send(1'b0, 4'd0, 5'd31);  collect(0, 1'b0);
        send(1'b1, 4'd2, 5'd5);   collect(0, 1'b0);

        // Reset at E3 while in CALC discards the partial result
        send(1'b0, 4'd5, 5'd12);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("midrst_in_ready", 8'(in_ready), 8'd1);
        check("midrst_out_valid", 8'(out_valid), 8'd0);
        check("midrst_operand", 8'(operand), 8'd0);
        check("midrst_err", 8'(err), 8'd0);
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check("midrst_no_result", 8'(out_valid), 8'd0);
        send(1'b0, 4'd1, 5'd1);   collect(0, 1'b0);

        // Reset wins over a simultaneous in_valid
        ctrl     = 1'b0;
        A        = 4'd2;
        q        = 5'd7;
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstvalid_in_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check("rstvalid_no_result", 8'(out_valid), 8'd0);
        check("rstvalid_still_idle", 8'(in_ready), 8'd1);

        // Inputs toggled while busy must not disturb or restart the operation
        send(1'b1, 4'd9, 5'd3);   collect(2, 1'b1);
        send(1'b0, 4'd7, 5'd20);  collect(0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
